scoreboard: RTL and testbench

In-order instruction scoreboard between decode and commit. It stores each decoded `scoreboard_entry` in a circular buffer and assigns the entry's `trans_id`. Functional units write results back by `trans_id`, and the block presents the oldest completed entry to commit. It also provides operand-forwarding and busy lookups for two source registers.

---
 rtl/scoreboard_pkg.sv | 24 ++
 rtl/scoreboard.sv | 173 +++++++++++++++++
 tb/tb_scoreboard.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/scoreboard_pkg.sv
// Shared types for the in-order scoreboard: the exception record raised by
// functional units and the per-instruction entry tracked from decode to commit.
package scoreboard_pkg;

  typedef struct packed {
    logic [63:0] cause;
    logic [63:0] tval;
    logic        valid;
  } exception;

  typedef struct packed {
    logic [63:0] pc;
    logic [4:0]  trans_id;
    logic [3:0]  fu;
    logic [6:0]  op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [63:0] result;
    logic        valid;
    exception    ex;
  } scoreboard_entry;

endpackage

// File: rtl/scoreboard.sv
// scoreboard: in-order instruction scoreboard between decode and commit.
// Decoded entries are stored in a circular buffer; the slot index becomes the
// entry's trans_id. Functional units write results back by trans_id, and the
// oldest entry is presented to commit once complete. Two source-register
// lookups report the youngest in-flight producer's result or busy status.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   flush_i                  discard every in-flight entry
//   decoded_instr_*          issue handshake; ack = valid & !full & !flush
//   issue_trans_id_o         slot that the offered entry will occupy
//   full_o                   every slot occupied
//   wb_*_i                   per-port writeback (strobe, slot, data, exception)
//   commit_*                 head entry, its completion flag and consume strobe
//   rs1_*/rs2_*              operand forwarding / busy lookups
module scoreboard
  import scoreboard_pkg::*;
#(
  parameter int unsigned NR_ENTRIES  = 8,
  parameter int unsigned NR_WB_PORTS = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  scoreboard_entry        decoded_instr_i,
  input  logic                   decoded_instr_valid_i,
  output logic                   decoded_instr_ack_o,
  output logic [4:0]             issue_trans_id_o,
  output logic                   full_o,
  input  logic [NR_WB_PORTS-1:0] wb_valid_i,
  input  logic [4:0]             wb_trans_id_i [NR_WB_PORTS],
  input  logic [63:0]            wb_data_i     [NR_WB_PORTS],
  input  exception               wb_ex_i       [NR_WB_PORTS],
  output scoreboard_entry        commit_instr_o,
  output logic                   commit_valid_o,
  input  logic                   commit_ack_i,
  input  logic [4:0]             rs1_i,
  input  logic [4:0]             rs2_i,
  output logic [63:0]            rs1_o,
  output logic [63:0]            rs2_o,
  output logic                   rs1_valid_o,
  output logic                   rs2_valid_o,
  output logic                   rs1_busy_o,
  output logic                   rs2_busy_o
);

  localparam int unsigned PTR_W = $clog2(NR_ENTRIES);
  localparam int unsigned CNT_W = PTR_W + 1;

  scoreboard_entry        mem_q [NR_ENTRIES];
  scoreboard_entry        mem_d [NR_ENTRIES];
  logic [NR_ENTRIES-1:0]  occ_q, occ_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;

  logic issue;
  logic commit;

  // full comes from registered count only: a commit in the same cycle does
  // not open a slot for a simultaneous issue.
  assign full_o              = (count_q == CNT_W'(NR_ENTRIES));
  assign decoded_instr_ack_o = decoded_instr_valid_i & ~full_o & ~flush_i;
  assign issue_trans_id_o    = 5'(wr_ptr_q);
  assign commit_instr_o      = mem_q[rd_ptr_q];
  assign commit_valid_o      = occ_q[rd_ptr_q] & mem_q[rd_ptr_q].valid;

  assign issue  = decoded_instr_ack_o;
  assign commit = commit_ack_i & commit_valid_o;

  // --------------------------------------------------------------------------
  // Next-state: issue, writeback, commit; flush overrides everything.
  // --------------------------------------------------------------------------
  always_comb begin
    mem_d    = mem_q;
    occ_d    = occ_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CNT_W'(issue) - CNT_W'(commit);

    if (issue) begin
      mem_d[wr_ptr_q]          = decoded_instr_i;
      mem_d[wr_ptr_q].trans_id = 5'(wr_ptr_q);
      // An entry that already carries an exception needs no writeback.
      mem_d[wr_ptr_q].valid    = decoded_instr_i.ex.valid;
      occ_d[wr_ptr_q]          = 1'b1;
      wr_ptr_d                 = wr_ptr_q + PTR_W'(1);
    end

    // Ascending port order lets the highest-indexed port win on a collision.
    // Only registered occupancy qualifies a writeback, so the slot being
    // issued this cycle can never be hit.
    for (int unsigned p = 0; p < NR_WB_PORTS; p++) begin
      if (wb_valid_i[p] && (32'(wb_trans_id_i[p]) < NR_ENTRIES) &&
          occ_q[wb_trans_id_i[p][PTR_W-1:0]]) begin
        mem_d[wb_trans_id_i[p][PTR_W-1:0]].result = wb_data_i[p];
        mem_d[wb_trans_id_i[p][PTR_W-1:0]].valid  = 1'b1;
        if (wb_ex_i[p].valid) begin
          mem_d[wb_trans_id_i[p][PTR_W-1:0]].ex = wb_ex_i[p];
        end
      end
    end

    if (commit) begin
      occ_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = rd_ptr_q + PTR_W'(1);
    end

    if (flush_i) begin
      mem_d    = mem_q;
      occ_d    = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q    <= '{default: '0};
      occ_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      occ_q    <= occ_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // --------------------------------------------------------------------------
  // Operand lookup. Occupied slots form the contiguous run rd_ptr..wr_ptr-1,
  // so scanning wr_ptr, wr_ptr+1, ... wr_ptr-1 and letting later hits
  // overwrite earlier ones leaves the youngest producer selected.
  // --------------------------------------------------------------------------
  logic [1:0][4:0]  lk_rs;
  logic [1:0][63:0] lk_data;
  logic [1:0]       lk_valid;
  logic [1:0]       lk_busy;

  assign lk_rs = {rs2_i, rs1_i};

  always_comb begin
    logic [PTR_W-1:0] slot;
    slot     = '0;
    lk_data  = '0;
    lk_valid = '0;
    lk_busy  = '0;
    for (int unsigned l = 0; l < 2; l++) begin
      if (lk_rs[l] != '0) begin
        for (int unsigned k = 0; k < NR_ENTRIES; k++) begin
          slot = wr_ptr_q + PTR_W'(k);
          if (occ_q[slot] && (mem_q[slot].rd == lk_rs[l])) begin
            lk_data[l]  = mem_q[slot].result;
            lk_valid[l] = mem_q[slot].valid & ~mem_q[slot].ex.valid;
            lk_busy[l]  = ~mem_q[slot].valid;
          end
        end
      end
    end
  end

  assign rs1_o       = lk_data[0];
  assign rs2_o       = lk_data[1];
  assign rs1_valid_o = lk_valid[0];
  assign rs2_valid_o = lk_valid[1];
  assign rs1_busy_o  = lk_busy[0];
  assign rs2_busy_o  = lk_busy[1];

endmodule

// File: tb/tb_scoreboard.sv
// Self-checking bench for scoreboard: directed scenarios followed by random
// traffic, all compared against a queue-based model of the in-flight window.
module tb_scoreboard;
  import scoreboard_pkg::*;

  localparam int unsigned NR = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            flush;
  scoreboard_entry din;
  logic            dvalid;
  logic            ack;
  logic [4:0]      tid;
  logic            full;
  logic [1:0]      wbv;
  logic [4:0]      wbid [2];
  logic [63:0]     wbd  [2];
  exception        wbex [2];
  scoreboard_entry cinstr;
  logic            cvalid;
  logic            cack;
  logic [4:0]      rs1, rs2;
  logic [63:0]     rs1_o, rs2_o;
  logic            rs1_v, rs2_v, rs1_b, rs2_b;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Model: in-flight entries oldest first, plus the next slot to be handed out.
  scoreboard_entry mq[$];
  int unsigned     next_id = 0;

  always #5 clk = ~clk;

  scoreboard #(.NR_ENTRIES(NR), .NR_WB_PORTS(2)) dut (
    .clk_i                 (clk),
    .rst_ni                (rst_n),
    .flush_i               (flush),
    .decoded_instr_i       (din),
    .decoded_instr_valid_i (dvalid),
    .decoded_instr_ack_o   (ack),
    .issue_trans_id_o      (tid),
    .full_o                (full),
    .wb_valid_i            (wbv),
    .wb_trans_id_i         (wbid),
    .wb_data_i             (wbd),
    .wb_ex_i               (wbex),
    .commit_instr_o        (cinstr),
    .commit_valid_o        (cvalid),
    .commit_ack_i          (cack),
    .rs1_i                 (rs1),
    .rs2_i                 (rs2),
    .rs1_o                 (rs1_o),
    .rs2_o                 (rs2_o),
    .rs1_valid_o           (rs1_v),
    .rs2_valid_o           (rs2_v),
    .rs1_busy_o            (rs1_b),
    .rs2_busy_o            (rs2_b)
  );

  task automatic check_eq(input string tag, input logic [511:0] got,
                          input logic [511:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic scoreboard_entry rand_entry();
    scoreboard_entry e;
    e.pc       = {$urandom(), $urandom()};
    e.trans_id = 5'($urandom());
    e.fu       = 4'($urandom());
    e.op       = 7'($urandom());
    e.rs1      = 5'($urandom());
    e.rs2      = 5'($urandom());
    e.rd       = 5'($urandom_range(0, 7));
    e.result   = {$urandom(), $urandom()};
    e.valid    = 1'($urandom());
    e.ex.cause = {$urandom(), $urandom()};
    e.ex.tval  = {$urandom(), $urandom()};
    e.ex.valid = ($urandom_range(0, 9) == 0);
    return e;
  endfunction

  // {result, usable, busy} of the youngest in-flight writer of rs.
  function automatic logic [65:0] exp_lookup(input logic [4:0] rs);
    if (rs == 5'd0) return '0;
    for (int i = int'(mq.size()) - 1; i >= 0; i--)
      if (mq[i].rd == rs)
        return {mq[i].result, mq[i].valid & ~mq[i].ex.valid, ~mq[i].valid};
    return '0;
  endfunction

  task automatic idle();
    flush  = 1'b0;
    dvalid = 1'b0;
    din    = '0;
    cack   = 1'b0;
    wbv    = '0;
    rs1    = '0;
    rs2    = '0;
    for (int p = 0; p < 2; p++) begin
      wbid[p] = '0;
      wbd[p]  = '0;
      wbex[p] = '0;
    end
  endtask

  // Check outputs for the currently driven inputs, advance the model across
  // the coming edge, then return at the next falling edge with inputs idle.
  task automatic step();
    logic            exp_ack, exp_cv;
    scoreboard_entry e;
    #1;
    exp_ack = dvalid && (mq.size() < NR) && !flush;
    exp_cv  = (mq.size() > 0) && mq[0].valid;
    check_eq("ack", ack, exp_ack);
    check_eq("trans_id", tid, next_id);
    check_eq("full", full, mq.size() == NR);
    check_eq("commit_valid", cvalid, exp_cv);
    if (mq.size() > 0) check_eq("commit_instr", cinstr, mq[0]);
    check_eq("rs1", {rs1_o, rs1_v, rs1_b}, exp_lookup(rs1));
    check_eq("rs2", {rs2_o, rs2_v, rs2_b}, exp_lookup(rs2));

    if (flush) begin
      mq.delete();
      next_id = 0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (wbv[p]) begin
          for (int i = 0; i < int'(mq.size()); i++) begin
            if (mq[i].trans_id == wbid[p]) begin
              e        = mq[i];
              e.result = wbd[p];
              e.valid  = 1'b1;
              if (wbex[p].valid) e.ex = wbex[p];
              mq[i]    = e;
            end
          end
        end
      end
      if (cack && exp_cv) void'(mq.pop_front());
      if (exp_ack) begin
        e          = din;
        e.trans_id = 5'(next_id);
        e.valid    = din.ex.valid;
        mq.push_back(e);
        next_id = (next_id + 1) % NR;
      end
    end
    @(negedge clk);
    idle();
  endtask

  task automatic issue_plain(input logic [4:0] rd);
    din       = rand_entry();
    din.rd    = rd;
    din.ex.valid = 1'b0;
    dvalid    = 1'b1;
  endtask

  task automatic wb(input int p, input logic [4:0] id, input logic [63:0] d);
    wbv[p]  = 1'b1;
    wbid[p] = id;
    wbd[p]  = d;
    wbex[p] = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    rs1 = 5'd5;
    #12;
    check_eq("rst_full", full, 1'b0);
    check_eq("rst_cvalid", cvalid, 1'b0);
    check_eq("rst_ack", ack, 1'b0);
    check_eq("rst_tid", tid, 5'd0);
    check_eq("rst_cinstr", cinstr, '0);
    check_eq("rst_rs1", {rs1_o, rs1_v, rs1_b}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    idle();

    // Reset then issue, out-of-order writeback.
    for (int i = 0; i < 3; i++) begin
      issue_plain(5'(5 + i));
      #1 check_eq("A_tid", tid, i);
      step();
    end
    wb(0, 5'd2, 64'hAA); step();
    wb(0, 5'd0, 64'hBB); step();
    #1 check_eq("A_head_res", cinstr.result, 64'hBB);
    cack = 1'b1; step();
    cack = 1'b1; step();
    wb(1, 5'd1, 64'hCC); step();
    cack = 1'b1; step();
    cack = 1'b1; step();

    // Full, blocked issue alongside commit, wrap-around.
    flush = 1'b1; step();
    for (int i = 0; i < 8; i++) begin issue_plain(5'(i)); step(); end
    #1 check_eq("B_full", full, 1'b1);
    wb(0, 5'd0, 64'h1); step();
    issue_plain(5'd1); cack = 1'b1;
    #1 check_eq("B_ack_full", ack, 1'b0);
    step();
    issue_plain(5'd1);
    #1 check_eq("B_not_full", full, 1'b0);
    check_eq("B_wrap_tid", tid, 5'd0);
    check_eq("B_wrap_ack", ack, 1'b1);
    step();

    // Forwarding from the youngest writer.
    flush = 1'b1; step();
    issue_plain(5'd3); step();
    issue_plain(5'd3); step();
    wb(0, 5'd0, 64'h11); step();
    rs1 = 5'd3;
    #1 check_eq("C_busy", {rs1_v, rs1_b}, 2'b01);
    step();
    wb(0, 5'd1, 64'h22); step();
    rs1 = 5'd3; rs2 = 5'd0;
    #1 check_eq("C_fwd", {rs1_o, rs1_v, rs1_b}, {64'h22, 2'b10});
    check_eq("C_x0", {rs2_o, rs2_v, rs2_b}, '0);
    step();

    // Exception on arrival; same-slot dual-port writeback.
    flush = 1'b1; step();
    din = rand_entry(); din.ex.valid = 1'b1; dvalid = 1'b1; step();
    issue_plain(5'd4);
    #1 check_eq("D_ex_cvalid", cvalid, 1'b1);
    step();
    wb(0, 5'd1, 64'h111); wb(1, 5'd1, 64'h222); step();
    cack = 1'b1; step();
    #1 check_eq("D_port_win", cinstr.result, 64'h222);
    step();

    // Flush with issue and writeback in the same cycle.
    flush = 1'b1; step();
    for (int i = 0; i < 4; i++) begin issue_plain(5'(i + 1)); step(); end
    flush = 1'b1; issue_plain(5'd2); wb(0, 5'd0, 64'h5);
    #1 check_eq("E_ack_flush", ack, 1'b0);
    step();
    issue_plain(5'd2);
    #1 check_eq("E_cvalid", cvalid, 1'b0);
    check_eq("E_tid", tid, 5'd0);
    step();

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      flush  = ($urandom_range(0, 49) == 0);
      dvalid = ($urandom_range(0, 9) < 7);
      din    = rand_entry();
      cack   = ($urandom_range(0, 9) < 6);
      for (int p = 0; p < 2; p++) begin
        wbv[p]  = ($urandom_range(0, 9) < 4);
        if (mq.size() > 0 && $urandom_range(0, 9) < 8)
          wbid[p] = mq[$urandom_range(0, mq.size() - 1)].trans_id;
        else
          wbid[p] = 5'($urandom_range(0, 7));
        wbd[p]       = {$urandom(), $urandom()};
        wbex[p].cause = {$urandom(), $urandom()};
        wbex[p].tval  = {$urandom(), $urandom()};
        wbex[p].valid = ($urandom_range(0, 7) == 0);
      end
      rs1 = 5'($urandom_range(0, 7));
      rs2 = 5'($urandom_range(0, 7));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
